// File: rtl/int_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_add_pkg
//  Description : Shared constants and segment-geometry helpers for the
//                configurable-accuracy pipelined adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_add_pkg;

    localparam int SAT_OFF = 0;
    localparam int SAT_ON  = 1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

    // Segments are ceil(bw/ns) wide with the top one taking the remainder.
    // The clamp keeps every segment at least one bit wide when the
    // remainder would otherwise be zero or negative.
    function automatic int seg_lo(input int bw, input int ns, input int k);
        int seg_ceil;
        int lo;
        seg_ceil = (bw + ns - 1) / ns;
        lo       = k * seg_ceil;
        if (lo > bw - ns + k) begin
            lo = bw - ns + k;
        end
        return lo;
    endfunction

    function automatic int seg_w(input int bw, input int ns, input int k);
        return seg_lo(bw, ns, k + 1) - seg_lo(bw, ns, k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_int_add_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : config_int_add_pipe_if
//  Description : Operand and result valid/ready channels of the adder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface config_int_add_pipe_if #(
    parameter int BWOP = 32,
    parameter int TRW  = 7
);
    logic            in_vld;
    logic            in_rdy;
    logic [BWOP-1:0] a;
    logic [BWOP-1:0] b;
    logic [TRW-1:0]  trunc;
    logic            sat;
    logic            out_vld;
    logic            out_rdy;
    logic [BWOP-1:0] c;
    logic            cout;

    modport master (
        output in_vld, a, b, trunc, sat, out_rdy,
        input  in_rdy, out_vld, c, cout
    );

    modport slave (
        input  in_vld, a, b, trunc, sat, out_rdy,
        output in_rdy, out_vld, c, cout
    );
endinterface
`default_nettype wire

// File: rtl/int_add_seg.sv
`default_nettype none
// ============================================================================
//  Module      : int_add_seg
//  Description : One combinational ripple segment of the split adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_add_seg #(
    parameter int SW = 16
) (
    input  wire  [SW-1:0] x,
    input  wire  [SW-1:0] y,
    input  wire           ci,
    output logic [SW-1:0] s,
    output logic          co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};

endmodule
`default_nettype wire

// File: rtl/config_int_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : config_int_add_pipe
//  Description : Pipelined unsigned adder with per-transaction operand
//                truncation, optional saturation and valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_int_add_pipe
    import int_add_pkg::*;
#(
    parameter int BWOP = 32,
    parameter int NSTG = 2,
    parameter int TRW  = 7
) (
    input wire                   clk,
    input wire                   rst,
    config_int_add_pipe_if.slave bus
);

    logic [TRW-1:0]  w_trunc;
    logic [BWOP-1:0] w_mask;
    logic [NSTG-1:0] w_vld;
    logic [NSTG:0]   w_adv;

    assign w_trunc = bus.trunc;
    // Shift amounts at or beyond the width yield zero, clearing the whole mask.
    assign w_mask  = {BWOP{1'b1}} << w_trunc;

    always_comb begin
        w_adv       = '0;
        w_adv[NSTG] = bus.out_rdy;
        for (int k = NSTG - 1; k >= 0; k--) begin
            w_adv[k] = ~w_vld[k] | w_adv[k+1];
        end
    end

    assign bus.in_rdy  = w_adv[0];
    assign bus.out_vld = w_vld[NSTG-1];

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = seg_lo(BWOP, NSTG, k);
        localparam int W  = seg_w(BWOP, NSTG, k);
        localparam int HI = LO + W;

        // Operand bits from this segment upward; the low sum bits done so far.
        logic [BWOP-LO-1:0] w_a;
        logic [BWOP-LO-1:0] w_b;
        logic               w_ci;
        logic               w_sat;
        logic               w_vin;
        logic [W-1:0]       w_seg;
        logic               w_co;
        logic [HI-1:0]      w_sum;
        logic               r_v;

        if (k == 0) begin : g_head
            assign w_a   = bus.a & w_mask;
            assign w_b   = bus.b & w_mask;
            assign w_ci  = 1'b0;
            assign w_sat = bus.sat;
            assign w_vin = bus.in_vld;
            assign w_sum = w_seg;
        end else begin : g_body
            assign w_a   = g_stg[k-1].g_mid.r_a;
            assign w_b   = g_stg[k-1].g_mid.r_b;
            assign w_ci  = g_stg[k-1].g_mid.r_cy;
            assign w_sat = g_stg[k-1].g_mid.r_sat;
            assign w_vin = g_stg[k-1].r_v;
            assign w_sum = {w_seg, g_stg[k-1].g_mid.r_s};
        end

        int_add_seg #(
            .SW (W)
        ) u_seg (
            .x  (w_a[W-1:0]),
            .y  (w_b[W-1:0]),
            .ci (w_ci),
            .s  (w_seg),
            .co (w_co)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_v <= 1'b0;
            end else if (w_adv[k]) begin
                r_v <= w_vin;
            end
        end

        assign w_vld[k] = r_v;

        if (k < NSTG - 1) begin : g_mid
            logic [BWOP-HI-1:0] r_a;
            logic [BWOP-HI-1:0] r_b;
            logic [HI-1:0]      r_s;
            logic               r_cy;
            logic               r_sat;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_s   <= '0;
                    r_cy  <= 1'b0;
                    r_sat <= 1'b0;
                end else if (w_adv[k] && w_vin) begin
                    r_a   <= w_a[BWOP-LO-1:W];
                    r_b   <= w_b[BWOP-LO-1:W];
                    r_s   <= w_sum;
                    r_cy  <= w_co;
                    r_sat <= w_sat;
                end
            end
        end else begin : g_tail
            logic [BWOP-1:0] r_c;
            logic            r_cout;

            // Saturation is resolved here so the output port is a plain flop.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_c    <= '0;
                    r_cout <= 1'b0;
                end else if (w_adv[k] && w_vin) begin
                    r_c    <= (w_sat && w_co) ? {BWOP{1'b1}} : w_sum;
                    r_cout <= w_co;
                end
            end

            assign bus.c    = r_c;
            assign bus.cout = r_cout;
        end
    end

endmodule
`default_nettype wire
